l2_flush_ctrl: RTL
==================

L2_FLUSH_CTRL -- requirements
Module: l2_flush_ctrl

Interface
REQ-001 SHALL have parameter SETS, default 256, number of L2 sets (power of two, at least 2).
REQ-002 SHALL have parameter WAYS, default 8, number of L2 ways (power of two, at least 2).
REQ-003 SHALL have parameter N_REQS, default 4, number of outstanding-request entries.
REQ-004 SHALL have port clk, input, 1, clock; reset is rst, asynchronous, active-low.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_start, input, 1, single-cycle request to start a whole-cache flush.
REQ-007 SHALL have port stall, input, 1, pause the walk (driven by set_conflict or fwd_stall).
REQ-008 SHALL have port reqs_cnt, input, clog2(N_REQS)+1, number of free request entries.
REQ-009 SHALL have ports rd_en (output, 1), rd_set (output, clog2(SETS)) and rd_way (output, clog2(WAYS)), a tag/state array read.
REQ-010 SHALL have ports rsp_valid_line (input, 1) and rsp_dirty (input, 1), the line state one cycle after rd_en.
REQ-011 SHALL have ports evict_valid (output, 1), evict_ready (input, 1), evict_set and evict_way, a writeback request.
REQ-012 SHALL have ports inval_en (output, 1), inval_set and inval_way, invalidating a clean line.
REQ-013 SHALL have port fill_reqs_flush, output, 1, a one-cycle pulse on each evict handshake that allocates a request entry.
REQ-014 SHALL have ports ongoing_flush (output, 1) and flush_done (output, 1, single-cycle pulse).

Function
REQ-015 SHALL implement FSM states IDLE, READ, RSP, EVICT, INVAL, NEXT, DRAIN and DONE.
REQ-016 SHALL walk the cache with way as the inner loop and set as the outer loop: (0,0), (0,1) … (0,WAYS-1), (1,0) … up to (SETS-1, WAYS-1).
REQ-017 IDLE: on flush_start, SHALL clear the set and way counters, set ongoing_flush and go to READ.
REQ-018 READ: when stall=0, SHALL pulse rd_en with the current set/way and go to RSP; when stall=1, SHALL hold with rd_en=0.
REQ-019 RSP: SHALL go to EVICT if valid and dirty, to INVAL if valid and clean, and to NEXT if invalid.
REQ-020 EVICT: SHALL assert evict_valid only while reqs_cnt≠0; once asserted, evict_valid, evict_set and evict_way SHALL stay stable until evict_ready.
REQ-021 On the evict handshake, SHALL pulse fill_reqs_flush for one cycle, pulse inval_en in the same cycle, and go to NEXT.
REQ-022 INVAL: SHALL pulse inval_en for one cycle, then go to NEXT.
REQ-023 NEXT: SHALL increment way; on way wrap, SHALL reset way to 0 and increment set; after the last set and last way, SHALL go to DRAIN, otherwise to READ.
REQ-024 Counters SHALL be one bit wider than the index so that wrap is detectable; the index outputs SHALL use the low bits.
REQ-025 DRAIN: SHALL wait until reqs_cnt==N_REQS, then go to DONE.
REQ-026 DONE: SHALL pulse flush_done for one cycle, clear ongoing_flush, and go to IDLE.
REQ-027 SHALL ignore flush_start in any state other than IDLE.
REQ-028 stall SHALL affect only READ; handshakes already in progress in EVICT or INVAL SHALL complete.
REQ-029 The minimum cost per invalid line SHALL be 3 cycles (READ, RSP, NEXT).

Reset
REQ-030 SHALL asynchronously set state=IDLE, clear both counters, and drive ongoing_flush, flush_done, rd_en, evict_valid, inval_en and fill_reqs_flush to 0.
REQ-031 On reset during a flush, SHALL abandon the walk with no flush_done pulse.

Structure
REQ-032 The L2_SETS, L2_WAYS, N_REQS, L2_SET_BITS, L2_WAY_BITS and REQS_BITS_P1 constants and the FSM state enum SHALL live in the shared cache constants/types package.
REQ-033 SHALL contain one sub-module, l2_flush_iter, holding the set/way counters and the last-line detect.

Verification
REQ-034 Test with SETS=4, WAYS=2 and all lines invalid: flush_start → 8 rd_en pulses, 0 evicts, then flush_done with ongoing_flush low afterwards.
REQ-035 Test with line (2,1) dirty and reqs_cnt=4, evict_ready=1: exactly one evict with evict_set=2 and evict_way=1, and a coincident fill_reqs_flush pulse.
REQ-036 Test with reqs_cnt=0 while in EVICT for 5 cycles: evict_valid=0 throughout, and it asserts the cycle after reqs_cnt becomes 1.
REQ-037 Test with evict_ready low for 3 cycles: evict_valid and the index outputs hold stable, and the handshake completes on the 4th cycle.
REQ-038 Test with stall=1 at READ of (1,0) for 4 cycles: no rd_en; the walk resumes at (1,0) with no line skipped.
REQ-039 Test with rst asserted at set 2 and then released: outputs read 0 and state is IDLE, and a second flush_start restarts from (0,0).

Source files
------------

// File: rtl/l2_flush_ctrl_pkg.sv
// Shared L2 cache constants and flush controller FSM encoding.
package l2_flush_ctrl_pkg;

    localparam int L2_SETS      = 256;
    localparam int L2_WAYS      = 8;
    localparam int N_REQS       = 4;
    localparam int L2_SET_BITS  = $clog2(L2_SETS);
    localparam int L2_WAY_BITS  = $clog2(L2_WAYS);
    localparam int REQS_BITS_P1 = $clog2(N_REQS) + 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RSP,
        EVICT,
        INVAL,
        NEXT,
        DRAIN,
        DONE
    } flush_state_e;

endpackage

// File: rtl/l2_flush_ctrl_if.sv
// Flush controller <-> cache/request-tracker signal bundle; master is the controller side.
interface l2_flush_ctrl_if #(
    parameter int SETS   = l2_flush_ctrl_pkg::L2_SETS,
    parameter int WAYS   = l2_flush_ctrl_pkg::L2_WAYS,
    parameter int N_REQS = l2_flush_ctrl_pkg::N_REQS
);
    localparam int SET_BITS  = $clog2(SETS);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int REQS_BITS = $clog2(N_REQS) + 1;

    logic                 flush_start;
    logic                 stall;
    logic [REQS_BITS-1:0] reqs_cnt;
    logic                 rd_en;
    logic [SET_BITS-1:0]  rd_set;
    logic [WAY_BITS-1:0]  rd_way;
    logic                 rsp_valid_line;
    logic                 rsp_dirty;
    logic                 evict_valid;
    logic                 evict_ready;
    logic [SET_BITS-1:0]  evict_set;
    logic [WAY_BITS-1:0]  evict_way;
    logic                 inval_en;
    logic [SET_BITS-1:0]  inval_set;
    logic [WAY_BITS-1:0]  inval_way;
    logic                 fill_reqs_flush;
    logic                 ongoing_flush;
    logic                 flush_done;

    modport master (
        input  flush_start, stall, reqs_cnt, rsp_valid_line, rsp_dirty, evict_ready,
        output rd_en, rd_set, rd_way, evict_valid, evict_set, evict_way,
               inval_en, inval_set, inval_way, fill_reqs_flush, ongoing_flush, flush_done
    );

    modport slave (
        output flush_start, stall, reqs_cnt, rsp_valid_line, rsp_dirty, evict_ready,
        input  rd_en, rd_set, rd_way, evict_valid, evict_set, evict_way,
               inval_en, inval_set, inval_way, fill_reqs_flush, ongoing_flush, flush_done
    );

endinterface

// File: rtl/l2_flush_iter.sv
// Set/way walk counters (way inner, set outer) with last-line detect.
module l2_flush_iter #(
    parameter int SETS = l2_flush_ctrl_pkg::L2_SETS,
    parameter int WAYS = l2_flush_ctrl_pkg::L2_WAYS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     advance,
    output logic [$clog2(SETS)-1:0]  set_idx,
    output logic [$clog2(WAYS)-1:0]  way_idx,
    output logic                     last
);
    localparam int SET_BITS = $clog2(SETS);
    localparam int WAY_BITS = $clog2(WAYS);
    localparam logic [SET_BITS:0] SET_ONE = 1;
    localparam logic [WAY_BITS:0] WAY_ONE = 1;

    // The extra top bit on each counter flags the wrap without a compare.
    logic [SET_BITS:0] set_cnt, set_inc;
    logic [WAY_BITS:0] way_cnt, way_inc;
    logic              way_wrap;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        way_inc  = way_cnt + WAY_ONE;
        set_inc  = set_cnt + SET_ONE;
        way_wrap = way_inc[WAY_BITS];
        last     = way_wrap && set_inc[SET_BITS];
    end

    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            set_cnt <= '0;
            way_cnt <= '0;
        end else if (clear) begin
            set_cnt <= '0;
            way_cnt <= '0;
        end else if (advance) begin
            if (way_wrap) begin
                way_cnt <= '0;
                set_cnt <= set_inc;
            end else begin
                way_cnt <= way_inc;
            end
        end
    end

    assign set_idx = set_cnt[SET_BITS-1:0];
    assign way_idx = way_cnt[WAY_BITS-1:0];

endmodule

// File: rtl/l2_flush_ctrl.sv
// Whole-cache L2 flush walker: reads every line, writes back dirty ones, invalidates all valid ones.
module l2_flush_ctrl #(
    parameter int SETS   = l2_flush_ctrl_pkg::L2_SETS,
    parameter int WAYS   = l2_flush_ctrl_pkg::L2_WAYS,
    parameter int N_REQS = l2_flush_ctrl_pkg::N_REQS
) (
    input  logic            clk,
    input  logic            rst,
    l2_flush_ctrl_if.master bus
);
    import l2_flush_ctrl_pkg::*;

    localparam int SET_BITS  = $clog2(SETS);
    localparam int WAY_BITS  = $clog2(WAYS);
    localparam int REQS_BITS = $clog2(N_REQS) + 1;
    localparam logic [REQS_BITS-1:0] REQS_FULL = REQS_BITS'(N_REQS);

    flush_state_e        state, state_d;
    logic                evict_valid_q, evict_valid_d;
    logic                iter_clear, iter_advance, last_line;
    logic                handshake, reqs_free;
    logic [SET_BITS-1:0] set_idx;
    logic [WAY_BITS-1:0] way_idx;

    l2_flush_iter #(.SETS(SETS), .WAYS(WAYS)) u_iter (
        .clk     (clk),
        .rst     (rst),
        .clear   (iter_clear),
        .advance (iter_advance),
        .set_idx (set_idx),
        .way_idx (way_idx),
        .last    (last_line)
    );

    assign handshake = evict_valid_q && bus.evict_ready;
    assign reqs_free = (bus.reqs_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            evict_valid_q <= 1'b0;
        end else begin
            state         <= state_d;
            evict_valid_q <= evict_valid_d;
        end
    end

    always_comb begin
        state_d        = state;
        evict_valid_d  = evict_valid_q;
        iter_clear     = 1'b0;
        iter_advance   = 1'b0;
        bus.rd_en      = 1'b0;
        bus.inval_en   = 1'b0;
        bus.flush_done = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.flush_start) begin
                    iter_clear = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                if (!bus.stall) begin
                    bus.rd_en = 1'b1;
                    state_d   = RSP;
                end
            end
            RSP: begin
                if (!bus.rsp_valid_line) begin
                    state_d = NEXT;
                end else if (bus.rsp_dirty) begin
                    // Request the writeback on entry when an entry is already free.
                    evict_valid_d = reqs_free;
                    state_d       = EVICT;
                end else begin
                    state_d = INVAL;
                end
            end
            EVICT: begin
                if (handshake) begin
                    evict_valid_d = 1'b0;
                    bus.inval_en  = 1'b1;
                    state_d       = NEXT;
                end else if (!evict_valid_q) begin
                    evict_valid_d = reqs_free;
                end
            end
            INVAL: begin
                bus.inval_en = 1'b1;
                state_d      = NEXT;
            end
            NEXT: begin
                iter_advance = 1'b1;
                state_d      = last_line ? DRAIN : READ;
            end
            DRAIN: begin
                if (bus.reqs_cnt == REQS_FULL) state_d = DONE;
            end
            DONE: begin
                bus.flush_done = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Every index output tracks the walk position; it is frozen outside NEXT.
    assign bus.rd_set          = set_idx;
    assign bus.rd_way          = way_idx;
    assign bus.evict_set       = set_idx;
    assign bus.evict_way       = way_idx;
    assign bus.inval_set       = set_idx;
    assign bus.inval_way       = way_idx;
    assign bus.evict_valid     = evict_valid_q;
    assign bus.fill_reqs_flush = handshake;
    assign bus.ongoing_flush   = (state != IDLE);

endmodule
